// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch path, the load/store path and the
// shared memory port. The arbiter takes the slave view; the environment takes the master view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_be, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_be, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin; otherwise data priority with a fetch starvation counter.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   lock_q, lock_d;
  logic   lock_data_q, lock_data_d;
  logic   sel_data;
  logic   conflict;

`ifdef MEM_ARB_RR_EN
  // Set when data should win the next conflict, i.e. fetch was granted last.
  logic prio_data_q, prio_data_d;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  assign conflict = bus.i_req & bus.d_req;

  // A latched offer must be honoured until the memory accepts it.
  always_comb begin
    sel_data = bus.d_req;
    if (lock_q) begin
      sel_data = lock_data_q;
    end else if (conflict) begin
`ifdef MEM_ARB_RR_EN
      sel_data = prio_data_q;
`else
      sel_data = (starve_cnt_q != LIMIT);
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    lock_data_d = lock_data_q;
`ifdef MEM_ARB_RR_EN
    prio_data_d = prio_data_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    bus.i_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rdata  = bus.m_rdata;
    bus.d_rdata  = bus.m_rdata;
    bus.m_req    = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_be     = 4'h0;
    bus.m_addr   = 32'h0;
    bus.m_wdata  = 32'h0;
    bus.busy     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          bus.m_req = 1'b1;
          if (sel_data) begin
            bus.m_we    = bus.d_we;
            bus.m_be    = bus.d_be;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
          end else begin
            bus.m_be    = 4'hF;
            bus.m_addr  = bus.i_addr;
          end
          if (bus.m_gnt) begin
            lock_d = 1'b0;
            if (sel_data) begin
              bus.d_gnt = 1'b1;
              state_d   = WAIT_D;
            end else begin
              bus.i_gnt = 1'b1;
              state_d   = WAIT_I;
            end
`ifdef MEM_ARB_RR_EN
            prio_data_d = ~sel_data;
`else
            // A data grant while fetch is waiting counts as a fetch loss.
            if (!sel_data) begin
              starve_cnt_d = 4'd0;
            end else if (bus.i_req && (starve_cnt_q < LIMIT)) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
`endif
          end else begin
            lock_d      = 1'b1;
            lock_data_d = sel_data;
          end
        end
      end
      WAIT_I: begin
        if (bus.m_rvalid) begin
          bus.i_rvalid = 1'b1;
          state_d      = IDLE;
        end
      end
      WAIT_D: begin
        if (bus.m_rvalid) begin
          bus.d_rvalid = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every output is held low while reset is asserted, including pass-through data.
    if (!reset) begin
      bus.i_gnt    = 1'b0;
      bus.d_gnt    = 1'b0;
      bus.i_rvalid = 1'b0;
      bus.d_rvalid = 1'b0;
      bus.i_rdata  = 32'h0;
      bus.d_rdata  = 32'h0;
      bus.m_req    = 1'b0;
      bus.m_we     = 1'b0;
      bus.m_be     = 4'h0;
      bus.m_addr   = 32'h0;
      bus.m_wdata  = 32'h0;
      bus.busy     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lock_q      <= 1'b0;
      lock_data_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      prio_data_q <= 1'b1;
`else
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      lock_data_q <= lock_data_d;
`ifdef MEM_ARB_RR_EN
      prio_data_q <= prio_data_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level arbitration model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference model state: fetch losses since its last grant / whether data is preferred next.
  int model_losses;
  bit model_pref_d;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic idle_inputs;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 0;
    tick(); tick();
    reset = 1;
    tick();
    model_losses = 0;
    model_pref_d = 1;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 0;
    tick();
    bus.i_req = 1; bus.i_addr = 32'h44; bus.d_req = 1; bus.d_addr = 32'h88;
    bus.m_gnt = 1; bus.m_rvalid = 1; bus.m_rdata = 32'hFFFF_FFFF;
    settle();
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_req, bus.m_we, bus.busy} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0000000", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_req, bus.m_we, bus.busy});
    else passed++;
    checks++;
    if ({bus.m_addr, bus.m_be, bus.d_rdata, bus.i_rdata} !== '0)
      $display("FAIL reset_data: got addr %h be %h drdata %h irdata %h expected all 0", bus.m_addr, bus.m_be, bus.d_rdata, bus.i_rdata);
    else passed++;
    idle_inputs();
    reset = 1;
    tick();
    settle();
    checks++;
    if ({bus.busy, bus.m_req} !== 2'b00)
      $display("FAIL reset_release: got busy/m_req %b expected 00", {bus.busy, bus.m_req});
    else passed++;
    model_losses = 0;
    model_pref_d = 1;
  endtask

  task automatic test_fetch_alone;
    do_reset();
    bus.i_req = 1; bus.i_addr = 32'h100; bus.m_gnt = 1;
    settle();
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.m_req} !== 3'b101)
      $display("FAIL fetch_gnt: got i_gnt/d_gnt/m_req %b expected 101", {bus.i_gnt, bus.d_gnt, bus.m_req});
    else passed++;
    checks++;
    if (bus.m_addr !== 32'h100 || bus.m_we !== 1'b0 || bus.m_be !== 4'hF)
      $display("FAIL fetch_mbus: got addr %h we %b be %h expected 100 0 f", bus.m_addr, bus.m_we, bus.m_be);
    else passed++;
    tick();
    bus.i_req = 0; bus.m_gnt = 0;
    settle();
    checks++;
    if ({bus.busy, bus.m_req, bus.i_rvalid} !== 3'b100)
      $display("FAIL fetch_wait: got busy/m_req/i_rvalid %b expected 100", {bus.busy, bus.m_req, bus.i_rvalid});
    else passed++;
    tick();
    bus.m_rvalid = 1; bus.m_rdata = 32'hDEADBEEF;
    settle();
    checks++;
    if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF || bus.d_rvalid !== 1'b0)
      $display("FAIL fetch_resp: got i_rvalid %b i_rdata %h d_rvalid %b expected 1 deadbeef 0", bus.i_rvalid, bus.i_rdata, bus.d_rvalid);
    else passed++;
    tick();
    bus.m_rvalid = 0;
    settle();
    checks++;
    if (bus.busy !== 1'b0)
      $display("FAIL fetch_done: got busy %b expected 0", bus.busy);
    else passed++;
  endtask

  task automatic test_conflict;
    string order;
    byte   got;
    byte   want;
`ifdef MEM_ARB_RR_EN
    order = "DIDIDIDI";
`else
    order = "DDDIDDDI";
`endif
    do_reset();
    bus.i_req = 1; bus.i_addr = 32'h300;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h400;
    for (int k = 0; k < 8; k++) begin
      want = order[k];
      bus.m_gnt = 1;
      settle();
      got = (bus.d_gnt && !bus.i_gnt) ? "D" : (bus.i_gnt && !bus.d_gnt) ? "I" : "-";
      checks++;
      if (got !== want)
        $display("FAIL conflict_order[%0d]: got %s expected %s", k, got, want);
      else passed++;
      tick();
      bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'(k);
      settle();
      checks++;
      if ({bus.i_rvalid, bus.d_rvalid} !== ((want == "D") ? 2'b01 : 2'b10))
        $display("FAIL conflict_rvalid[%0d]: got i/d %b expected owner %s", k, {bus.i_rvalid, bus.d_rvalid}, want);
      else passed++;
      tick();
      bus.m_rvalid = 0;
    end
    idle_inputs();
  endtask

  task automatic test_backpressure;
    do_reset();
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234;
    bus.m_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.i_req = 1; bus.i_addr = 32'h200;
      end
      settle();
      checks++;
      if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_be !== 4'b0011 || bus.m_addr !== 32'h40 ||
          bus.m_wdata !== 32'h1234 || bus.d_gnt !== 1'b0 || bus.i_gnt !== 1'b0)
        $display("FAIL bp_hold[%0d]: got req %b we %b be %b addr %h wdata %h gnt i/d %b%b expected 1 1 0011 40 1234 00",
                 c, bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata, bus.i_gnt, bus.d_gnt);
      else passed++;
      tick();
    end
    bus.m_gnt = 1;
    settle();
    checks++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01)
      $display("FAIL bp_gnt: got i/d gnt %b expected 01", {bus.i_gnt, bus.d_gnt});
    else passed++;
    tick();
    bus.d_req = 0; bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h0;
    settle();
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid} !== 2'b01)
      $display("FAIL bp_ack: got i/d rvalid %b expected 01", {bus.i_rvalid, bus.d_rvalid});
    else passed++;
    tick();
    bus.m_rvalid = 0; bus.m_gnt = 1;
    settle();
    checks++;
    if ({bus.i_gnt, bus.m_addr} !== {1'b1, 32'h200})
      $display("FAIL bp_fetch_after: got i_gnt %b addr %h expected 1 200", bus.i_gnt, bus.m_addr);
    else passed++;
    tick();
    idle_inputs();
    bus.m_rvalid = 1;
    tick();
    bus.m_rvalid = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h80; bus.m_gnt = 1;
    tick();
    bus.d_req = 0; bus.m_gnt = 0;
    settle();
    checks++;
    if (bus.busy !== 1'b1)
      $display("FAIL rmid_inflight: got busy %b expected 1", bus.busy);
    else passed++;
    reset = 0;
    bus.d_req = 1; bus.i_req = 1; bus.m_rvalid = 1; bus.m_rdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if ({bus.busy, bus.m_req, bus.d_rvalid, bus.i_rvalid, bus.d_gnt, bus.i_gnt} !== 6'b0 || bus.d_rdata !== 32'h0)
      $display("FAIL rmid_outputs: got busy/mreq/drv/irv/dgnt/ignt %b d_rdata %h expected 000000 0",
               {bus.busy, bus.m_req, bus.d_rvalid, bus.i_rvalid, bus.d_gnt, bus.i_gnt}, bus.d_rdata);
    else passed++;
    tick();
    idle_inputs();
    reset = 1;
    tick();
    bus.m_rvalid = 1; bus.m_rdata = 32'h5A5A5A5A;
    settle();
    checks++;
    if ({bus.busy, bus.d_rvalid, bus.i_rvalid} !== 3'b000)
      $display("FAIL rmid_late_rvalid: got busy/d_rvalid/i_rvalid %b expected 000", {bus.busy, bus.d_rvalid, bus.i_rvalid});
    else passed++;
    tick();
    bus.m_rvalid = 0;
  endtask

  task automatic test_spurious;
    do_reset();
    bus.m_rvalid = 1; bus.m_rdata = 32'h1111_2222;
    settle();
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.busy} !== 3'b000)
      $display("FAIL spurious_rvalid: got i/d rvalid/busy %b expected 000", {bus.i_rvalid, bus.d_rvalid, bus.busy});
    else passed++;
    tick();
    bus.m_rvalid = 0; bus.i_req = 1; bus.i_addr = 32'h10; bus.m_gnt = 1;
    settle();
    checks++;
    if ({bus.busy, bus.i_gnt} !== 2'b01)
      $display("FAIL spurious_idle: got busy/i_gnt %b expected 01", {bus.busy, bus.i_gnt});
    else passed++;
    tick();
    idle_inputs();
    bus.m_rvalid = 1;
    tick();
    bus.m_rvalid = 0;
  endtask

  task automatic test_random;
    bit          ip, dp, win_d;
    logic [31:0] ia, da, dw, rd;
    logic        dwe;
    logic [3:0]  dbe;
    int          stall, lat;
    do_reset();
    ip = 0; dp = 0;
    ia = 0; da = 0; dw = 0; dwe = 0; dbe = 0;
    for (int t = 0; t < 60; t++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom & 32'hFFFF_FFFC; end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom); dbe = 4'($urandom);
      end
      if (!ip && !dp) begin ip = 1; ia = $urandom & 32'hFFFF_FFFC; end
      bus.i_req = ip; bus.i_addr = ia;
      bus.d_req = dp; bus.d_addr = da; bus.d_wdata = dw; bus.d_we = dwe; bus.d_be = dbe;
      // The winner is decided when the request is first offered.
`ifdef MEM_ARB_RR_EN
      win_d = (ip && dp) ? model_pref_d : dp;
`else
      win_d = (ip && dp) ? (model_losses < LIMIT) : dp;
`endif
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        bus.m_gnt = 0;
        settle();
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== (win_d ? da : ia) || bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0)
          $display("FAIL rand_stall[%0d]: got req %b addr %h gnt %b%b expected 1 %h 00",
                   t, bus.m_req, bus.m_addr, bus.i_gnt, bus.d_gnt, win_d ? da : ia);
        else passed++;
        tick();
        if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom & 32'hFFFF_FFFC; bus.i_req = 1; bus.i_addr = ia; end
        if (!dp && $urandom_range(0, 1) == 1) begin
          dp = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom); dbe = 4'($urandom);
          bus.d_req = 1; bus.d_addr = da; bus.d_wdata = dw; bus.d_we = dwe; bus.d_be = dbe;
        end
      end
      bus.m_gnt = 1;
      settle();
      checks++;
      if ({bus.i_gnt, bus.d_gnt} !== (win_d ? 2'b01 : 2'b10))
        $display("FAIL rand_gnt[%0d]: got i/d gnt %b expected %s wins", t, {bus.i_gnt, bus.d_gnt}, win_d ? "data" : "fetch");
      else passed++;
      checks++;
      if (win_d ? ({bus.m_addr, bus.m_we, bus.m_be, bus.m_wdata} !== {da, dwe, dbe, dw})
                : ({bus.m_addr, bus.m_we, bus.m_be} !== {ia, 1'b0, 4'hF}))
        $display("FAIL rand_mbus[%0d]: got addr %h we %b be %h wdata %h", t, bus.m_addr, bus.m_we, bus.m_be, bus.m_wdata);
      else passed++;
      if (win_d) begin
        dp = 0;
        if (ip) model_losses = (model_losses < LIMIT) ? model_losses + 1 : LIMIT;
      end else begin
        ip = 0;
        model_losses = 0;
      end
      model_pref_d = !win_d;
      tick();
      bus.m_gnt = 0; bus.i_req = ip; bus.d_req = dp;
      lat = $urandom_range(1, 3);
      for (int l = 1; l <= lat; l++) begin
        rd = $urandom;
        bus.m_rvalid = (l == lat); bus.m_rdata = rd;
        settle();
        checks++;
        if ({bus.busy, bus.m_req} !== 2'b10)
          $display("FAIL rand_wait[%0d]: got busy/m_req %b expected 10", t, {bus.busy, bus.m_req});
        else passed++;
        if (l == lat) begin
          checks++;
          if ({bus.i_rvalid, bus.d_rvalid} !== (win_d ? 2'b01 : 2'b10) || (win_d ? bus.d_rdata : bus.i_rdata) !== rd)
            $display("FAIL rand_resp[%0d]: got i/d rvalid %b rdata %h expected owner %s data %h",
                     t, {bus.i_rvalid, bus.d_rvalid}, win_d ? bus.d_rdata : bus.i_rdata, win_d ? "data" : "fetch", rd);
          else passed++;
        end
        tick();
      end
      bus.m_rvalid = 0;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_alone();
    test_conflict();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the pipeline's instruction-fetch path and its load/store path. It accepts one request from each side over a req/gnt handshake, picks a winner, forwards it to the memory port, and routes the response back to the owner. Only one transaction is outstanding at a time. Sits between the datapath's `pc`/`instr` and `aluout`/`writedata`/`readdata` nets and the memory model.

## Interface
- `STARVE_LIMIT`, default 3: consecutive conflict losses by fetch before fetch is forced to win (range 1..15).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request; held with `i_addr` until `i_gnt`.
- `i_addr` in 32: fetch address.
- `i_gnt` out 1: fetch request accepted this cycle.
- `i_rvalid` out 1: fetch data valid.
- `i_rdata` out 32: fetch data.
- `d_req` in 1: data request; held with `d_we`, `d_be`, `d_addr` and `d_wdata` until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in 4: byte enables.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data request accepted.
- `d_rvalid` out 1: load data valid, or store acknowledged.
- `d_rdata` out 32: load data.
- `m_req` out 1: memory request.
- `m_we` out 1: memory write enable.
- `m_be` out 4: memory byte enables.
- `m_addr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_gnt` in 1: memory accepted the request.
- `m_rvalid` in 1: memory response; asserted for both reads and writes.
- `m_rdata` in 32: memory read data.
- `busy` out 1: a transaction is outstanding.

## Operation
- States:
  - IDLE: may issue a request.
  - WAIT_I: fetch transaction outstanding.
  - WAIT_D: data transaction outstanding.
- In IDLE with any request, the selected requester's fields drive the `m_*` outputs combinationally and `m_req` = 1.
  - `m_gnt` = 1 raises the owner's `*_gnt` in the same cycle and moves the FSM to WAIT_I or WAIT_D.
  - If a fetch is accepted, `m_we` = 0 and `m_be` = 4'hF; `m_wdata` is don't-care.
- Selection lock: once `m_req` has been asserted without `m_gnt`, the chosen requester is latched and kept until granted. Once a transfer has been offered, no switching happens.
- In WAIT_x, `m_req` = 0. When `m_rvalid` = 1:
  - the owner's `*_rvalid` = 1 and `*_rdata` = `m_rdata` in that same cycle;
  - the FSM returns to IDLE.
- `*_rdata` passes `m_rdata` through and is meaningful only when the matching `*_rvalid` is high. The non-owner's `*_rvalid` stays 0.
- `m_rvalid` arriving in IDLE is ignored; no `*_rvalid` is raised.
- Fixed priority (default):
  - Data wins a conflict.
  - `starve_cnt` (4 bits) counts fetch losses on conflict and clears whenever fetch is granted.
  - When `starve_cnt` == `STARVE_LIMIT`, fetch wins the next conflict.
  - `starve_cnt` saturates at `STARVE_LIMIT`.
- A lone requester always wins, regardless of counters.
- `busy` = 1 in WAIT_I and WAIT_D.

## Timing
- Grant latency is 0 cycles: request and grant can occur in the same cycle the memory accepts.
- Response is the memory latency plus 0 cycles (combinational routing).
- Minimum spacing is 2 cycles per transaction: the issue cycle plus at least one WAIT cycle. No issue is allowed in the same cycle as the `m_rvalid` return.
- Reset (asserted low, asynchronous):
  - FSM goes to IDLE; `starve_cnt` = 0; the lock is cleared; the RR pointer points to data.
  - All outputs are 0 while `reset` = 0.
  - A transaction in flight when reset asserts is abandoned. Its late `m_rvalid` lands in IDLE and is dropped.
- Requesters must not deassert `*_req` before `*_gnt`. Doing so is a protocol violation and the behaviour is undefined.

## Configuration
- `MEM_ARB_RR_EN`:
  - Defined: round-robin arbitration. A 1-bit last-grant pointer is kept; on a conflict, the requester not granted last wins. `starve_cnt` and `STARVE_LIMIT` are unused.
  - Undefined: data-priority arbitration with the starvation counter, as described under Operation.

## Test plan
- Fetch alone:
  - Stimulus: `i_req` = 1, `i_addr` = 0x100, `m_gnt` = 1 at once, `m_rvalid` 2 cycles later with `m_rdata` = 0xDEADBEEF.
  - Required: `i_gnt` in the issue cycle, `m_addr` = 0x100 with `m_we` = 0, then `i_rvalid` = 1 with `i_rdata` = 0xDEADBEEF; `d_rvalid` stays 0.
- Conflict, data priority, `STARVE_LIMIT` = 3:
  - Stimulus: both requests held continuously, each transaction 1-cycle latency.
  - Required: grant order is D, D, D, I, D, D, D, I.
  - With `MEM_ARB_RR_EN` defined, the required order is D, I, D, I.
- Memory backpressure:
  - Stimulus: `d_req` with a store (`d_be` = 4'b0011, `d_wdata` = 0x1234); `m_gnt` held at 0 for 3 cycles; `i_req` rises in the 2nd cycle.
  - Required: the `m_*` outputs stay on the data request unchanged until `m_gnt`; `d_gnt` follows; `d_rvalid` appears on `m_rvalid`.
- Reset mid-transaction:
  - Stimulus: assert `reset` = 0 while in WAIT_D, release it, then pulse `m_rvalid`.
  - Required: all outputs are 0 during reset, `busy` = 0 afterwards, and no `d_rvalid` is raised.
- Spurious response:
  - Stimulus: `m_rvalid` = 1 in IDLE with no request pending.
  - Required: `i_rvalid` = `d_rvalid` = 0, and the state stays IDLE.
